// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: 2-FF oversampling, frame check, E0/F0 prefix decode,
// first-word fall-through key-event FIFO and snake direction with no-reversal rule.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [2:0]       direction,
    output logic             dir_changed,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             fifo_full,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] DIR_W   = 3'b011;
    localparam logic [2:0] DIR_A   = 3'b010;
    localparam logic [2:0] DIR_S   = 3'b001;
    localparam logic [2:0] DIR_D   = 3'b000;
    localparam logic [2:0] DIR_RST = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CHECK
    } rx_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    logic            scl_s1_q, scl_s2_q, scl_prev_q;
    logic            sda_s1_q, sda_s2_q;
    logic            fall;

    rx_state_e       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            par_q, par_d;
    logic            stop_q, stop_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            byte_good;
    logic            err_inc;

    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic            push;

    logic [2:0]      dir_q, dir_d;
    logic            dir_changed_q, dir_changed_d;

    logic [ERR_W-1:0] err_q;

    evt_t            mem_q [FIFO_DEPTH];
    evt_t            head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            empty, full, push_ok, pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
        end else begin
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
        end
    end

    assign fall = scl_prev_q & ~scl_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        stop_d    = stop_q;
        tmo_d     = tmo_q;
        byte_good = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                if (fall && !sda_s2_q) begin
                    state_d = S_DATA;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (fall) begin
                    tmo_d = '0;
                    if (state_q == S_DATA) begin
                        shift_d   = {sda_s2_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else if (state_q == S_PARITY) begin
                        par_d   = sda_s2_q;
                        state_d = S_STOP;
                    end else begin
                        stop_d  = sda_s2_q;
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th quiet cycle in a row.
                    tmo_d   = '0;
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if ((^{shift_q, par_q}) && stop_q) begin
                    byte_good = 1'b1;
                end else begin
                    err_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (err_inc) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_good) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Opposite pairs differ only in bit 1, so a request is blocked when the
    // current direction equals the request with bit 1 flipped.
    always_comb begin
        dir_d = dir_q;
        if (push && !brk_q) begin
            case (shift_q)
                8'h75:   dir_d = (dir_q == DIR_S) ? dir_q : DIR_W;
                8'h6B:   dir_d = (dir_q == DIR_D) ? dir_q : DIR_A;
                8'h72:   dir_d = (dir_q == DIR_W) ? dir_q : DIR_S;
                8'h74:   dir_d = (dir_q == DIR_A) ? dir_q : DIR_D;
                8'h29:   dir_d = DIR_RST;
                default: dir_d = dir_q;
            endcase
        end
        dir_changed_d = (dir_d != dir_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            dir_q         <= DIR_RST;
            dir_changed_q <= 1'b0;
            err_q         <= '0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            if (err_inc && (err_q != {ERR_W{1'b1}})) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_ok  = evt_ready & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{code: shift_q, ext: ext_q, brk: brk_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign evt_valid   = ~empty;
    assign evt_code    = empty ? 8'h00 : head.code;
    assign evt_ext     = empty ? 1'b0  : head.ext;
    assign evt_break   = empty ? 1'b0  : head.brk;
    assign fifo_full   = full;
    assign direction   = dir_q;
    assign dir_changed = dir_changed_q;
    assign err_cnt     = err_q;

endmodule
